game_cmd_scheduler: RTL and testbench

Sequences all state-changing commands into the Tetris game-control engine, one at a time. Merges the periodic gravity tick with debounced keyboard moves, buffers the moves, and arbitrates between the two sources. Issues each command over a valid/ready handshake and waits for the engine's completion and landing report. Sits between the keyboard decoder and the game-control engine, and replaces the engine's free-running drop tick and direct key sampling.

---
 rtl/game_cmd_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_game_cmd_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_cmd_scheduler.sv
// game_cmd_scheduler
// Serialises state-changing commands into the Tetris game-control engine.
// The periodic gravity drop and debounced keyboard moves are merged here:
// key presses are buffered in a small FIFO, gravity is held in a pending
// flag, and an FSM offers one command at a time over valid/ready. It then
// waits for the engine's done/landed report and requests a spawn when a
// drop lands.

module game_cmd_scheduler #(
  parameter int unsigned GRAVITY_PERIOD = 33554432,
  parameter int unsigned KEY_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] keyboard_signal,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic       cmd_src,
  input  logic       done,
  input  logic       landed,
  output logic       spawn_req,
  output logic       busy,
  output logic       key_overflow
);

  localparam int PTR_W = $clog2(KEY_FIFO_DEPTH);
  localparam int CNT_W = $clog2(GRAVITY_PERIOD);

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   FILL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FILL_FULL  = (PTR_W + 1)'(KEY_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] GRAV_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] GRAV_LAST  = CNT_W'(GRAVITY_PERIOD - 1);

  localparam logic [1:0] OP_DROP  = 2'b00;
  localparam logic       SRC_GRAV = 1'b0;
  localparam logic       SRC_KEY  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_SPAWN     = 2'd3
  } state_e;

  state_e state_q;

  // Key capture
  logic [2:0] kb_prev_q;
  logic       key_press;
  logic [1:0] key_op;

  // Key FIFO
  logic [1:0]       fifo_mem_q [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic             fifo_full, fifo_empty;
  logic             push_accept, pop, push_drop;
  logic [1:0]       fifo_head;

  // Gravity
  logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
  logic             grav_pending_q, grav_pending_d;
  logic             grav_wrap;

  // Arbitration
  logic take_grav, take_key;

  // Output registers
  logic       cmd_valid_q;
  logic [1:0] cmd_op_q;
  logic       cmd_src_q;
  logic       spawn_req_q;
  logic       key_overflow_q;

  // Press detection: a new non-idle move code (1xx) that differs from last cycle.
  always_comb begin
    key_press = enable && (state_q != ST_SPAWN) && keyboard_signal[2] &&
                (keyboard_signal != kb_prev_q);
    key_op    = keyboard_signal[1:0];
  end

  // Previous-key register used for edge detection; tracks the raw input every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_prev_q <= 3'b000;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value regardless of block ordering.
      kb_prev_q <= keyboard_signal;
    end
  end

  // Arbitration in IDLE: gravity first, then the oldest buffered key.
  always_comb begin
    fifo_full   = (fill_q == FILL_FULL);
    fifo_empty  = (fill_q == '0);
    fifo_head   = fifo_mem_q[rd_ptr_q];
    take_grav   = (state_q == ST_IDLE) && enable && grav_pending_q;
    take_key    = (state_q == ST_IDLE) && enable && !grav_pending_q && !fifo_empty;
    pop         = take_key;
    // A pop frees a slot in the same cycle, so a press against a full FIFO
    // is still stored when the head is leaving.
    push_accept = key_press && (!fifo_full || pop);
    push_drop   = key_press && fifo_full && !pop;
  end

  // FIFO pointer and fill-level next state; SPAWN discards everything queued.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (state_q == ST_SPAWN) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)         rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_accept, pop})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only read after the
    // fill level says it was written, so its power-up content is never seen.
    if (push_accept) fifo_mem_q[wr_ptr_q] <= key_op;
  end

  // Sticky overflow flag: set when a press finds the FIFO full with no pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_overflow_q <= 1'b0;
    end else if (push_drop) begin
      key_overflow_q <= 1'b1;
    end
  end

  // Gravity counter and pending flag next state.
  always_comb begin
    grav_wrap      = enable && (state_q != ST_SPAWN) && (grav_cnt_q == GRAV_LAST);
    grav_cnt_d     = grav_cnt_q + GRAV_ONE;
    grav_pending_d = grav_pending_q;
    if ((state_q == ST_SPAWN) || !enable || grav_wrap) begin
      grav_cnt_d = '0;
    end
    // A wrap wins over a clear in the same cycle; extra wraps coalesce.
    if (grav_wrap) begin
      grav_pending_d = 1'b1;
    end else if (take_grav || (state_q == ST_SPAWN)) begin
      grav_pending_d = 1'b0;
    end
  end

  // Gravity registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grav_cnt_q     <= '0;
      grav_pending_q <= 1'b0;
    end else begin
      grav_cnt_q     <= grav_cnt_d;
      grav_pending_q <= grav_pending_d;
    end
  end

  // Command sequencer: pick a source, offer it, wait for completion, spawn on landing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_DROP;
      cmd_src_q   <= SRC_GRAV;
      spawn_req_q <= 1'b0;
    end else begin
      spawn_req_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (take_grav) begin
            cmd_op_q    <= OP_DROP;
            cmd_src_q   <= SRC_GRAV;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else if (take_key) begin
            cmd_op_q    <= fifo_head;
            cmd_src_q   <= SRC_KEY;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Once offered, the command stays up until taken, even if enable drops.
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (done) begin
            if (landed && (cmd_op_q == OP_DROP)) begin
              spawn_req_q <= 1'b1;
              state_q     <= ST_SPAWN;
            end else begin
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_SPAWN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_src      = cmd_src_q;
  assign spawn_req    = spawn_req_q;
  assign busy         = (state_q != ST_IDLE);
  assign key_overflow = key_overflow_q;

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Testbench for game_cmd_scheduler: a scoreboard of expected commands is
// filled as stimulus is applied and drained on every observed handshake.
// A small engine responder pulses done one cycle after each handshake.

module tb_game_cmd_scheduler;

  localparam int GP    = 200;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] kb;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_src;
  logic       done;
  logic       landed;
  logic       spawn_req;
  logic       busy;
  logic       key_overflow;

  game_cmd_scheduler #(
    .GRAVITY_PERIOD (GP),
    .KEY_FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .keyboard_signal (kb),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_src         (cmd_src),
    .done            (done),
    .landed          (landed),
    .spawn_req       (spawn_req),
    .busy            (busy),
    .key_overflow    (key_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic       src;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   errors      = 0;
  int   checks      = 0;
  int   hs_count    = 0;
  int   spawn_count = 0;
  logic hs_seen     = 1'b0;
  logic land_next   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake is visible the half cycle before its edge.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      hs_count++;
      hs_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_op", {30'd0, cmd_op}, {30'd0, mon_e.op});
        check("cmd_src", {31'd0, cmd_src}, {31'd0, mon_e.src});
      end
    end
    if (rst_n && spawn_req) spawn_count++;
  end

  // Engine responder: done (with optional landed) one cycle after each handshake.
  initial begin
    done   = 1'b0;
    landed = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done   = 1'b0;
      landed = 1'b0;
      if (hs_seen) begin
        hs_seen = 1'b0;
        done    = 1'b1;
        landed  = land_next;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    kb        = 3'b000;
    cmd_ready = 1'b0;
    land_next = 1'b0;
    tick(3);
    exp_q.delete();
    hs_seen = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic press(input logic [2:0] code);
    kb = code;
    tick(1);
    kb = 3'b000;
    tick(1);
  endtask

  // Counts negedges until cmd_valid is seen, bounded by max.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < max);
  endtask

  task automatic wait_hs(input string tag, input int target, input int max);
    int n;
    n = 0;
    while (hs_count < target && n < max) begin
      tick(1);
      n++;
    end
    check(tag, hs_count, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int sbase;

    // Reset values with a key held during reset, then the first command.
    rst_n     = 1'b0;
    enable    = 1'b1;
    kb        = 3'b101;
    cmd_ready = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_op", cmd_op, 0);
    check("rst_cmd_src", cmd_src, 0);
    check("rst_spawn_req", spawn_req, 0);
    check("rst_busy", busy, 0);
    check("rst_key_overflow", key_overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('{op: 2'b01, src: 1'b1});
    @(negedge clk);
    check("t1_valid_c0", cmd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_c1", cmd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_c2", cmd_valid, 1);
    check("t1_op", cmd_op, 2'b01);
    check("t1_src", cmd_src, 1);
    check("t1_busy", busy, 1);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_hs("t1_hs", 1, 20);
    cmd_ready = 1'b0;
    kb        = 3'b000;

    // Held key yields exactly one command.
    do_reset();
    cmd_ready = 1'b1;
    base      = hs_count;
    exp_q.push_back('{op: 2'b10, src: 1'b1});
    kb = 3'b110;
    tick(50);
    kb = 3'b000;
    tick(10);
    check("t2_held_count", hs_count - base, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Gravity has priority over buffered keys.
    do_reset();
    base = hs_count;
    press(3'b100);
    tick(2);
    check("t3_key_offer", cmd_valid, 1);
    press(3'b101);
    press(3'b111);
    exp_q.push_back('{op: 2'b00, src: 1'b1});
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    exp_q.push_back('{op: 2'b01, src: 1'b1});
    exp_q.push_back('{op: 2'b11, src: 1'b1});
    tick(GP);
    cmd_ready = 1'b1;
    wait_hs("t3_hs", base + 4, 60);
    cmd_ready = 1'b0;
    check("t3_queue_empty", exp_q.size(), 0);

    // Overflow, then a press coinciding with a pop while full.
    do_reset();
    base = hs_count;
    wait_valid(GP + 10, n);
    check("t4_grav_latency", n, GP + 2);
    check("t4_grav_src", cmd_src, 0);
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    tick(1);
    press(3'b101);
    press(3'b110);
    press(3'b101);
    press(3'b110);
    check("t4_no_overflow_at_4", key_overflow, 0);
    exp_q.push_back('{op: 2'b01, src: 1'b1});
    exp_q.push_back('{op: 2'b10, src: 1'b1});
    exp_q.push_back('{op: 2'b01, src: 1'b1});
    exp_q.push_back('{op: 2'b10, src: 1'b1});
    press(3'b101);
    check("t4_overflow_at_5", key_overflow, 1);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(1);
    kb = 3'b111;
    exp_q.push_back('{op: 2'b11, src: 1'b1});
    tick(1);
    kb = 3'b000;
    @(negedge clk);
    check("t4_next_offer", cmd_valid, 1);
    check("t4_overflow_sticky", key_overflow, 1);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_hs("t4_hs", base + 6, 60);
    cmd_ready = 1'b0;
    check("t4_queue_empty", exp_q.size(), 0);

    // Landing: spawn pulse, FIFO flush, gravity restarts from zero.
    do_reset();
    base  = hs_count;
    sbase = spawn_count;
    wait_valid(GP + 10, n);
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    tick(1);
    press(3'b101);
    press(3'b110);
    land_next = 1'b1;
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    @(negedge clk);
    check("t5_spawn_before", spawn_req, 0);
    @(negedge clk);
    check("t5_spawn_pulse", spawn_req, 1);
    check("t5_spawn_busy", busy, 1);
    land_next = 1'b0;
    wait_valid(GP + 10, n);
    check("t5_regrav_latency", n, GP + 2);
    check("t5_regrav_src", cmd_src, 0);
    check("t5_spawn_count", spawn_count - sbase, 1);
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_hs("t5_hs", base + 2, 20);
    tick(10);
    check("t5_no_stale_keys", hs_count - base, 2);
    cmd_ready = 1'b0;
    check("t5_queue_empty", exp_q.size(), 0);

    // enable low during ISSUE: command held, then nothing until re-enabled.
    do_reset();
    base = hs_count;
    wait_valid(GP + 10, n);
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    @(posedge clk);
    #1;
    enable = 1'b0;
    tick(5);
    @(negedge clk);
    check("t6_valid_held", cmd_valid, 1);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(3);
    check("t6_hs", hs_count - base, 1);
    press(3'b101);
    tick(GP + 20);
    @(negedge clk);
    check("t6_idle_valid", cmd_valid, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_no_issue", hs_count - base, 1);
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_valid(GP + 10, n);
    check("t6_reenable_latency", n, GP + 2);
    check("t6_reenable_src", cmd_src, 0);
    exp_q.push_back('{op: 2'b00, src: 1'b0});
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_hs("t6_hs2", base + 2, 20);
    cmd_ready = 1'b0;
    tick(3);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
